// File: rtl/data_memory_hs_pkg.sv
// Shared constants, FSM state type and funct3 legality helper
// for the handshaked data memory.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stores only take signed size codes; loads also take BU/HU.
    function automatic logic legal_funct3(input logic write,
                                          input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!write)
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/response bundle between the memory stage and the data memory.
// One outstanding request; the response is a single-cycle strobe.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/data_memory_hs_load_align.sv
// Load lane selection and sign/zero extension of a 32-bit RAM word.
// Unknown size codes yield zero; the top flags those as errors.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
        endcase
    end

    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = 32'h0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0, w_half};
            F3_W:    o_data = i_word;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed RV32 data RAM with valid/ready requests and a
// fixed-latency response; one request in flight at a time.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
)(
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH_WORDS * 4);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0] r_mem [DEPTH_WORDS];

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;
    logic [31:0] r_pend_rdata;
    logic        r_pend_error;

    logic        w_ready;
    logic        w_acc;
    logic [31:0] w_off;
    logic [AW-3:0] w_idx;
    logic        w_misalign;
    logic        w_range_err;
    logic        w_err;
    logic [31:0] w_word;
    logic [31:0] w_ld_data;
    logic [31:0] w_result;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;

    assign w_ready = !reset && (r_state == IDLE || r_state == RESP);
    assign w_acc   = bus.req_valid && w_ready;

    assign w_off       = bus.req_addr - BASE_ADDR;
    assign w_idx       = w_off[AW-1:2];
    assign w_range_err = {1'b0, w_off} >= SPAN;

    always_comb begin
        w_misalign = 1'b0;
        if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU)
            && bus.req_addr[0])
            w_misalign = 1'b1;
        if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00)
            w_misalign = 1'b1;
    end

    assign w_err = !legal_funct3(bus.req_write, bus.req_funct3)
                   || w_misalign || w_range_err;

    assign w_word = r_mem[w_idx];

    dmem_load_align u_align (
        .i_word   (w_word),
        .i_lane   (bus.req_addr[1:0]),
        .i_funct3 (bus.req_funct3),
        .o_data   (w_ld_data)
    );

    assign w_result = (w_err || bus.req_write) ? 32'h0 : w_ld_data;

    // Store data is replicated so each lane sees its slice.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = bus.req_wdata;
        case (bus.req_funct3)
            F3_B: begin
                w_be     = 4'b0001 << bus.req_addr[1:0];
                w_wlanes = {4{bus.req_wdata[7:0]}};
            end
            F3_H: begin
                w_be     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{bus.req_wdata[15:0]}};
            end
            F3_W: begin
                w_be     = 4'b1111;
                w_wlanes = bus.req_wdata;
            end
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_acc && bus.req_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_error <= 1'b0;
            r_pend_rdata <= 32'h0;
            r_pend_error <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_acc) begin
                        if (LATENCY == 1) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_result;
                            r_resp_error <= w_err;
                        end else begin
                            r_state      <= BUSY;
                            r_cnt        <= 3'(LATENCY - 2);
                            r_pend_rdata <= w_result;
                            r_pend_error <= w_err;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (r_cnt == 3'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_pend_rdata;
                        r_resp_error <= r_pend_error;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_error = r_resp_error;

endmodule
